// File: rtl/alu_dec_pkg.sv
// Shared encodings for the registered ALU decoder: ALUOp classes, Funct codes,
// ALUControl codes and the decoder FSM states.
package alu_dec_pkg;

   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned CODE_W  = 3;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
   localparam logic [FN_W-1:0] FN_MUL = 6'b011100;
   localparam logic [FN_W-1:0] FN_AND = 6'b100100;
   localparam logic [FN_W-1:0] FN_OR  = 6'b100101;

   localparam logic [CODE_W-1:0] ALU_ADD = 3'b010;
   localparam logic [CODE_W-1:0] ALU_SUB = 3'b100;
   localparam logic [CODE_W-1:0] ALU_SLT = 3'b110;
   localparam logic [CODE_W-1:0] ALU_MUL = 3'b101;
   localparam logic [CODE_W-1:0] ALU_AND = 3'b000;
   localparam logic [CODE_W-1:0] ALU_OR  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier datapath, one multiplier bit per step.
// Sequenced by the decoder FSM through i_load/i_step; o_product holds the last result.
module seq_multiplier #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic                  o_last_c,
   output logic [2*DATA_W-1:0]   o_product
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [PROD_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [PROD_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_count;
   logic [PROD_W-1:0] r_product;
   logic [PROD_W-1:0] w_sum;

   // r_mcand is kept pre-shifted, so it always equals multiplicand << count
   assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_last_c  = (r_count == CNT_W'(DATA_W - 1));
   assign o_product = r_product;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else if (i_load) begin
         r_mcand  <= PROD_W'(i_a);
         r_mplier <= i_b;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_step) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CNT_W'(1);
         if (o_last_c) begin
            r_product <= w_sum;
         end
      end
   end

endmodule

// File: rtl/alu_decoder_seq.sv
// Registered ALUOp/Funct decoder with a Busy/Done handshake around an iterative multiply.
// Define ALU_DEC_LOGIC_EN to add the R-type AND/OR decodes.
module alu_decoder_seq
   import alu_dec_pkg::*;
#(
   parameter int unsigned FUNCT_W  = 6,
   parameter int unsigned ALUCTL_W = 3,
   parameter int unsigned DATA_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic [1:0]            ALUOp,
   input  logic [FUNCT_W-1:0]    Funct,
   input  logic [DATA_W-1:0]     SrcA,
   input  logic [DATA_W-1:0]     SrcB,
   output logic [ALUCTL_W-1:0]   ALUControl,
   output logic                  Busy,
   output logic                  Done,
   output logic [2*DATA_W-1:0]   MulResult
);

   state_t              r_state;
   state_t              w_next;
   logic [ALUCTL_W-1:0] r_alu_ctl;
   logic                r_busy;
   logic                r_done;
   logic [CODE_W-1:0]   w_code;
   logic                w_is_mul;
   logic                w_accept;
   logic                w_load;
   logic                w_step;
   logic                w_last;

   // Decode table
   always_comb begin
      w_code = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: w_code = ALU_ADD;
         ALUOP_SUB: w_code = ALU_SUB;
         ALUOP_RTYPE: begin
            case (Funct)
               FUNCT_W'(FN_ADD): w_code = ALU_ADD;
               FUNCT_W'(FN_SUB): w_code = ALU_SUB;
               FUNCT_W'(FN_SLT): w_code = ALU_SLT;
               FUNCT_W'(FN_MUL): w_code = ALU_MUL;
`ifdef ALU_DEC_LOGIC_EN
               FUNCT_W'(FN_AND): w_code = ALU_AND;
               FUNCT_W'(FN_OR):  w_code = ALU_OR;
`endif
               default:          w_code = ALU_ADD;
            endcase
         end
         default: w_code = ALU_ADD;
      endcase
   end

   assign w_is_mul = (ALUOp == ALUOP_RTYPE) && (Funct == FUNCT_W'(FN_MUL));

   // Next state and datapath controls; Start is only looked at in IDLE/DONE
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_load   = 1'b0;
      w_step   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            w_next = ST_IDLE;
            if (Start) begin
               w_accept = 1'b1;
               if (w_is_mul) begin
                  w_next = ST_MUL;
                  w_load = 1'b1;
               end else begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next = ST_DONE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_alu_ctl <= ALUCTL_W'(ALU_ADD);
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == ST_MUL);
         r_done  <= (w_next == ST_DONE);
         if (w_accept) begin
            r_alu_ctl <= ALUCTL_W'(w_code);
         end
      end
   end

   seq_multiplier #(
      .DATA_W (DATA_W)
   ) u_mult (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_a       (SrcA),
      .i_b       (SrcB),
      .o_last_c  (w_last),
      .o_product (MulResult)
   );

   assign ALUControl = r_alu_ctl;
   assign Busy       = r_busy;
   assign Done       = r_done;

endmodule

// File: tb/tb_alu_decoder_seq.sv
// Randomised self-checking bench for alu_decoder_seq against a transaction-level model
// (decode lookup plus a plain 64-bit product). Honours ALU_DEC_LOGIC_EN like the RTL.
module tb_alu_decoder_seq;

   localparam int unsigned FW = 6;
   localparam int unsigned CW = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 2 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          Start;
   logic [1:0]    ALUOp;
   logic [FW-1:0] Funct;
   logic [DW-1:0] SrcA;
   logic [DW-1:0] SrcB;
   logic [CW-1:0] ALUControl;
   logic          Busy;
   logic          Done;
   logic [PW-1:0] MulResult;

   int            total = 0;
   int            bad   = 0;
   logic [CW-1:0] exp_ctl;
   logic [PW-1:0] exp_prod;

   alu_decoder_seq #(
      .FUNCT_W  (FW),
      .ALUCTL_W (CW),
      .DATA_W   (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Start      (Start),
      .ALUOp      (ALUOp),
      .Funct      (Funct),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .Busy       (Busy),
      .Done       (Done),
      .MulResult  (MulResult)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] ref_code(input logic [1:0] op, input logic [FW-1:0] fn);
      if (op == 2'b01) return 3'b100;
      if (op != 2'b10) return 3'b010;
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b100;
         6'b101010: return 3'b110;
         6'b011100: return 3'b101;
`ifdef ALU_DEC_LOGIC_EN
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
`endif
         default:   return 3'b010;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request in the current cycle and follow it to its Done cycle.
   // Returns in the Done cycle so a following call is a back-to-back accept.
   task automatic run_op(input logic [1:0] op, input logic [FW-1:0] fn,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input bit poke);
      logic [CW-1:0] code;
      code  = ref_code(op, fn);
      Start = 1'b1;
      ALUOp = op;
      Funct = fn;
      SrcA  = a;
      SrcB  = b;
      tick;
      Start = 1'b0;
      ALUOp = 2'($urandom);
      Funct = FW'($urandom);
      SrcA  = $urandom;
      SrcB  = $urandom;
      exp_ctl = code;
      check("ctl_first", ALUControl, exp_ctl);
      if (code == 3'b101) begin
         for (int k = 1; k <= int'(DW); k++) begin
            check("busy_hi", Busy, 1);
            check("done_lo", Done, 0);
            if (poke && k == 5) begin
               Start = 1'b1;
               ALUOp = 2'b01;
            end else begin
               Start = 1'b0;
            end
            tick;
         end
         check("ctl_hold", ALUControl, exp_ctl);
         exp_prod = PW'(a) * PW'(b);
      end
      check("done_hi", Done, 1);
      check("busy_done", Busy, 0);
      check("prod", MulResult, exp_prod);
      check("ctl_done", ALUControl, exp_ctl);
   endtask

   task automatic idle_check;
      tick;
      check("idle_done", Done, 0);
      check("idle_busy", Busy, 0);
      check("idle_ctl", ALUControl, exp_ctl);
   endtask

   logic [1:0]    sw_op [12];
   logic [FW-1:0] sw_fn [12];
   logic [FW-1:0] fn_pool [7];

   initial begin
      rst   = 1'b1;
      Start = 1'b0;
      ALUOp = 2'b00;
      Funct = '0;
      SrcA  = '0;
      SrcB  = '0;
      exp_ctl  = 3'b010;
      exp_prod = '0;
      tick;
      tick;
      rst = 1'b0;
      check("rst_ctl", ALUControl, 3'b010);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_prod", MulResult, 0);

      // reset at multiply cycle 10 aborts; product stays 0
      Start = 1'b1; ALUOp = 2'b10; Funct = 6'b011100; SrcA = 32'd1234; SrcB = 32'd5678;
      tick;
      Start = 1'b0;
      repeat (9) tick;
      check("mul_c10_busy", Busy, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_ctl", ALUControl, 3'b010);
      check("abort_prod", MulResult, 0);
      tick;
      check("abort_idle_done", Done, 0);
      check("abort_idle_busy", Busy, 0);

      // decode sweep, with an idle cycle after each
      sw_op = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
      sw_fn = '{6'b100000, 6'b100010, 6'b101010, 6'b011100, 6'b100100, 6'b100101,
                6'b111111, 6'b000000, 6'b011100, 6'b011100, 6'b011100, 6'b101010};
      foreach (sw_op[i]) begin
         run_op(sw_op[i], sw_fn[i], $urandom, $urandom, 1'b0);
         idle_check();
      end

      // directed multiplies, ignored Start during Busy, back-to-back ADD
      run_op(2'b10, 6'b011100, 32'd7, 32'd6, 1'b0);
      check("mul_42", MulResult, 64'd42);
      idle_check();
      run_op(2'b10, 6'b011100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("mul_ones", MulResult, 64'hFFFF_FFFE_0000_0001);
      idle_check();
      run_op(2'b10, 6'b011100, 32'hDEAD_BEEF, 32'd0, 1'b1);
      check("mul_zero", MulResult, 64'd0);
      run_op(2'b10, 6'b011100, 32'd1000, 32'd999, 1'b1);
      run_op(2'b00, 6'b000000, $urandom, $urandom, 1'b0);
      check("b2b_prod", MulResult, 64'd999000);
      idle_check();

      // randomized traffic with random gaps
      fn_pool = '{6'b100000, 6'b100010, 6'b101010, 6'b011100, 6'b100100, 6'b100101, 6'b011100};
      for (int n = 0; n < 60; n++) begin
         logic [1:0]    op;
         logic [FW-1:0] fn;
         logic [DW-1:0] a;
         logic [DW-1:0] b;
         op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         fn = ($urandom_range(0, 5) == 0) ? FW'($urandom) : fn_pool[$urandom_range(0, 6)];
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = '1;
            2: begin a = '1; b = '1; end
            default: ;
         endcase
         run_op(op, fn, a, b, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idle_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
